// File: rtl/sha_bus_pkg.sv
// Shared types for the SHA / CPU write-port arbiter.
package sha_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  localparam int BUS_W = 32;

endpackage

// File: rtl/mux2x32to32.sv
// Two-way bus-wide select feeding the arbiter output register.
module mux2x32to32
  import sha_bus_pkg::*;
(
  input  logic [BUS_W-1:0] data0,
  input  logic [BUS_W-1:0] data1,
  input  logic             select,
  output logic [BUS_W-1:0] data_out
);

  assign data_out = select ? data1 : data0;

endmodule

// File: rtl/bus_share_arbiter.sv
// Round-robin burst arbiter sharing one 32-bit write path between two requesters,
// with a forced release after MAX_BURST beats and one registered output stage.
module bus_share_arbiter
  import sha_bus_pkg::*;
#(
  parameter int MAX_BURST  = 16,
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [BUS_W-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [BUS_W-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [BUS_W-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t       state, state_nxt;
  logic             prio;
  logic [CNT_W-1:0] beat_cnt;

  logic             gnt_src;
  logic             granted;
  logic             stage_free;
  logic             in_valid;
  logic             in_last;
  logic             other_valid;
  logic             xfer;
  logic             rel;
  logic [BUS_W-1:0] mux_data_p0;

  logic             vld_p1;
  logic [BUS_W-1:0] data_p1;
  logic             last_p1;
  logic             src_p1;

  assign gnt_src     = (state == ARB_GNT1);
  assign granted     = (state != ARB_IDLE);
  assign stage_free  = !vld_p1 || out_ready;
  assign in_valid    = gnt_src ? req1_valid : req0_valid;
  assign in_last     = gnt_src ? req1_last  : req0_last;
  assign other_valid = gnt_src ? req0_valid : req1_valid;
  assign xfer        = granted && in_valid && stage_free;
  // A grant ends on the requester's last beat or when the burst budget is spent
  assign rel         = xfer && (in_last || (beat_cnt == CNT_LAST));

  assign req0_ready  = (state == ARB_GNT0) && stage_free;
  assign req1_ready  = (state == ARB_GNT1) && stage_free;
  assign busy        = granted;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: begin
        if (req0_valid && req1_valid) state_nxt = prio ? ARB_GNT1 : ARB_GNT0;
        else if (req0_valid)          state_nxt = ARB_GNT0;
        else if (req1_valid)          state_nxt = ARB_GNT1;
      end
      ARB_GNT0, ARB_GNT1: begin
        if (rel) state_nxt = other_valid ? (gnt_src ? ARB_GNT0 : ARB_GNT1) : ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      prio     <= PRIO_RESET;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (rel) begin
        beat_cnt <= '0;
        prio     <= ~gnt_src;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // p0 -> p1: granted requester's beat selected and registered
  mux2x32to32 u_mux (
    .data0    (req0_data),
    .data1    (req1_data),
    .select   (gnt_src),
    .data_out (mux_data_p0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      src_p1  <= 1'b0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= mux_data_p0;
      last_p1 <= rel;
      src_p1  <= gnt_src;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_last  = last_p1;
  assign out_src   = src_p1;

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Scoreboard bench for bus_share_arbiter: a burst-level reference model predicts the
// output beat order; a monitor compares every beat the downstream accepts.
module tb_bus_share_arbiter;
  import sha_bus_pkg::*;

  localparam int MAXB     = 4;
  localparam bit PRIO_RST = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld0 = 1'b0, vld1 = 1'b0, lst0 = 1'b0, lst1 = 1'b0;
  logic [31:0] dat0 = '0, dat1 = '0;
  logic        out_ready = 1'b1;
  logic        req0_ready, req1_ready, out_valid, out_last, out_src, busy;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  bus_share_arbiter #(.MAX_BURST(MAXB), .PRIO_RESET(PRIO_RST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (vld0),
    .req0_data  (dat0),
    .req0_last  (lst0),
    .req0_ready (req0_ready),
    .req1_valid (vld1),
    .req1_data  (dat1),
    .req1_last  (lst1),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  typedef struct packed { logic [31:0] d; logic l; } beat_t;
  typedef struct packed { logic [31:0] d; logic l; logic s; } exp_t;

  beat_t q0[$], q1[$];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  bit    sb_en  = 1'b0;
  bit    mprio  = PRIO_RST;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && sb_en && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got data=%h last=%0b src=%0b, expected no beat",
                 out_data, out_last, out_src);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.d || out_last !== e.l || out_src !== e.s) begin
          errors++;
          $display("FAIL beat: got data=%h last=%0b src=%0b, expected data=%h last=%0b src=%0b",
                   out_data, out_last, out_src, e.d, e.l, e.s);
        end
      end
    end
  end

  // Burst-level model: grants alternate while both have work, each grant runs to
  // the burst's last beat or MAXB beats, and priority goes to the one not just served.
  task automatic build_expected();
    beat_t a0[$], a1[$];
    beat_t b;
    exp_t  e;
    int    s, n;
    a0 = q0;
    a1 = q1;
    while (a0.size() > 0 || a1.size() > 0) begin
      if (a0.size() > 0 && a1.size() > 0) s = mprio ? 1 : 0;
      else s = (a0.size() > 0) ? 0 : 1;
      n = 0;
      do begin
        b = (s == 0) ? a0.pop_front() : a1.pop_front();
        n++;
        e.d = b.d;
        e.s = (s == 1);
        e.l = b.l || (n == MAXB);
        sb.push_back(e);
      end while (!e.l && ((s == 0) ? a0.size() : a1.size()) > 0);
      mprio = (s == 0);
    end
  endtask

  task automatic add_burst(input int who, input int len, input logic [31:0] base, input bit with_last);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = base + 32'(k);
      b.l = with_last && (k == len - 1);
      if (who == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic add_random(input int who);
    int nb;
    nb = $urandom_range(0, 3);
    for (int k = 0; k < nb; k++) add_burst(who, $urandom_range(1, 6), $urandom, 1'b1);
  endtask

  // Starts and ends #1 after a rising edge.
  task automatic run_phase(input bit gaps, input bit rnd_rdy, input bit stall,
                           input bit chk_run, input string tag);
    int          idx0, idx1, cnt0, cnt1, cyc, runs, stall_cnt;
    bit          a0, a1, prev_ov, stall_req;
    logic [31:0] held;
    idx0 = 0; idx1 = 0; cnt0 = 0; cnt1 = 0; cyc = 0; runs = 0; stall_cnt = 0;
    prev_ov = 1'b0; stall_req = stall; held = '0;
    build_expected();
    out_ready = 1'b1;
    vld0 = (q0.size() > 0);
    vld1 = (q1.size() > 0);
    if (vld0) begin dat0 = q0[0].d; lst0 = q0[0].l; end
    if (vld1) begin dat1 = q1[0].d; lst1 = q1[0].l; end
    while ((idx0 < q0.size() || idx1 < q1.size() || sb.size() > 0) && cyc < 3000) begin
      @(negedge clk);
      a0 = vld0 && req0_ready;
      a1 = vld1 && req1_ready;
      if (out_valid && !prev_ov) runs++;
      prev_ov = out_valid;
      if (stall_cnt > 0) begin
        chk({tag, "_stall_ready"}, 32'(req0_ready | req1_ready), 32'd0);
        chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        if (stall_cnt == 4) held = out_data;
        else chk({tag, "_stall_data"}, out_data, held);
      end
      @(posedge clk); #1;
      cyc++;
      if (a0) begin
        cnt0 = (q0[idx0].l || cnt0 + 1 == MAXB) ? 0 : cnt0 + 1;
        idx0++;
      end
      if (a1) begin
        cnt1 = (q1[idx1].l || cnt1 + 1 == MAXB) ? 0 : cnt1 + 1;
        idx1++;
      end
      // A requester may pause only inside its own grant, which never affects arbitration
      vld0 = (idx0 < q0.size()) && !(gaps && cnt0 != 0 && $urandom_range(0, 2) == 0);
      vld1 = (idx1 < q1.size()) && !(gaps && cnt1 != 0 && $urandom_range(0, 2) == 0);
      if (idx0 < q0.size()) begin dat0 = q0[idx0].d; lst0 = q0[idx0].l; end
      if (idx1 < q1.size()) begin dat1 = q1[idx1].d; lst1 = q1[idx1].l; end
      if (stall_cnt > 0) stall_cnt--;
      if (stall_cnt == 0 && stall_req && out_valid) begin
        stall_cnt = 4;
        stall_req = 1'b0;
      end
      out_ready = (stall_cnt > 0) ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
    vld0 = 1'b0; vld1 = 1'b0; lst0 = 1'b0; lst1 = 1'b0; out_ready = 1'b1;
    chk({tag, "_drained"}, 32'(sb.size() + (q0.size() - idx0) + (q1.size() - idx1)), 32'd0);
    sb.delete();
    if (chk_run) chk({tag, "_no_bubble"}, 32'(runs), 32'd1);
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
  endtask

  task automatic lone0(input logic [31:0] d);
    exp_t e;
    e.d = d; e.l = 1'b1; e.s = 1'b0;
    sb.push_back(e);
    out_ready = 1'b1;
    vld0 = 1'b1; dat0 = d; lst0 = 1'b1;
    @(negedge clk);
    chk("lone_idle_busy", 32'(busy), 32'd0);
    chk("lone_idle_ready", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    chk("lone_grant_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lone_grant_ready", 32'(req0_ready), 32'd1);
    chk("lone_grant_outvalid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    vld0 = 1'b0; lst0 = 1'b0;
    @(negedge clk);
    chk("lone_out_valid", 32'(out_valid), 32'd1);
    chk("lone_back_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("lone_drained", 32'(sb.size()), 32'd0);
    mprio = 1'b1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vld0 = 1'b1; vld1 = 1'b1; dat0 = 32'hDEAD0000; dat1 = 32'hBEEF0000;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    vld0 = 1'b0; vld1 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    sb_en = 1'b1;

    add_burst(0, 2, 32'hB1, 1'b1);
    add_burst(1, 1, 32'hC1, 1'b1);
    run_phase(1'b0, 1'b0, 1'b0, 1'b1, "both_first");

    add_burst(0, 3, 32'hA1, 1'b1);
    run_phase(1'b0, 1'b0, 1'b0, 1'b1, "req0_three");
    @(negedge clk);
    chk("req0_three_busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;

    add_burst(1, 12, 32'h100, 1'b0);
    add_burst(0, 3, 32'h200, 1'b1);
    run_phase(1'b0, 1'b0, 1'b0, 1'b0, "forced_release");

    lone0(32'h66);
    lone0(32'h67);

    sb_en = 1'b0;
    out_ready = 1'b1;
    vld0 = 1'b1; dat0 = 32'h300; lst0 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      dat0 = dat0 + 32'd1;
    end
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready0", 32'(req0_ready), 32'd0);
    vld0 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    sb.delete();
    mprio = PRIO_RST;
    sb_en = 1'b1;

    add_burst(0, 2, 32'h400, 1'b1);
    add_burst(1, 2, 32'h500, 1'b1);
    run_phase(1'b0, 1'b0, 1'b0, 1'b1, "prio_after_rst");

    add_burst(0, 3, 32'h600, 1'b1);
    add_burst(0, 2, 32'h610, 1'b1);
    add_burst(1, 5, 32'h700, 1'b1);
    run_phase(1'b0, 1'b0, 1'b1, 1'b0, "stall");

    for (int p = 0; p < 25; p++) begin
      add_random(0);
      add_random(1);
      run_phase(1'b1, 1'b1, 1'b0, 1'b0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
